// File: rtl/neuron_operand_loader.sv
// Operand loader for the single-neuron datapath: banks N (weight, input) pairs, fires the neuron, captures its result.
// Optional RUN-state watchdog is compiled in with `define NEURON_LOADER_TIMEOUT_EN.
module neuron_operand_loader #(
    parameter int N       = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [7:0]           in_weight,
    input  logic [7:0]           in_data,
    output logic                 n_start,
    input  logic [$clog2(N):0]   n_readloc,
    output logic [7:0]           n_weight,
    output logic [7:0]           n_inp,
    input  logic [7:0]           n_ans,
    input  logic                 n_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [7:0]           out_data,
    output logic                 out_err,
    output logic                 busy
);

    localparam int PW  = $clog2(N);
    localparam int RLW = PW + 1;

    typedef enum logic [1:0] {
        S_LOAD,
        S_FIRE,
        S_RUN,
        S_OUT
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [PW-1:0]   wr_ptr;
    logic            blank;
    logic [7:0]      wbank [N];
    logic [7:0]      dbank [N];
    logic            load_hs;
    logic            last_hs;
    logic            capture;
    logic            expire;

    assign in_ready  = (state == S_LOAD);
    assign n_start   = (state == S_FIRE);
    assign out_valid = (state == S_OUT);
    assign busy      = (state != S_LOAD);

    // A handshake coinciding with clr is dropped
    assign load_hs = in_ready && in_valid && !clr;
    assign last_hs = load_hs && (wr_ptr == PW'(N - 1));
    assign capture = (state == S_RUN) && !blank && n_ready;

`ifdef NEURON_LOADER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] to_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt <= '0;
        end else if (clr || state != S_RUN) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    // A neuron result in the expiry cycle takes precedence over the abort
    assign expire = (state == S_RUN) && !capture && (to_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_err <= 1'b0;
        end else if (!clr && capture) begin
            out_err <= 1'b0;
        end else if (!clr && expire) begin
            out_err <= 1'b1;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign expire         = 1'b0;
    assign out_err        = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            S_LOAD: if (last_hs) state_nxt = S_FIRE;
            S_FIRE: state_nxt = S_RUN;
            S_RUN:  if (capture || expire) state_nxt = S_OUT;
            S_OUT:  if (out_ready) state_nxt = S_LOAD;
            default: state_nxt = S_LOAD;
        endcase
        if (clr) state_nxt = S_LOAD;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
        end else if (clr || last_hs) begin
            wr_ptr <= '0;
        end else if (load_hs) begin
            wr_ptr <= wr_ptr + 1'b1;
        end
    end

    // Marks the first RUN cycle so a stale n_ready from the prior evaluation is ignored
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blank <= 1'b0;
        end else begin
            blank <= (state == S_FIRE) && !clr;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                wbank[i] <= '0;
                dbank[i] <= '0;
            end
        end else if (load_hs) begin
            wbank[wr_ptr] <= in_weight;
            dbank[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_data <= '0;
        end else if (!clr && capture) begin
            out_data <= n_ans;
        end else if (!clr && expire) begin
            out_data <= 8'hFF;
        end
    end

    always_comb begin
        n_weight = '0;
        n_inp    = '0;
        for (int i = 0; i < N; i++) begin
            if (n_readloc == RLW'(i)) begin
                n_weight = wbank[i];
                n_inp    = dbank[i];
            end
        end
    end

endmodule

// File: tb/tb_neuron_operand_loader.sv
// Scoreboard bench for neuron_operand_loader (N=4, TIMEOUT=8); timeout cases run when NEURON_LOADER_TIMEOUT_EN is defined.
module tb_neuron_operand_loader;

    localparam int N       = 4;
    localparam int TIMEOUT = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic               clr;
    logic               in_valid;
    logic               in_ready;
    logic [7:0]         in_weight;
    logic [7:0]         in_data;
    logic               n_start;
    logic [$clog2(N):0] n_readloc;
    logic [7:0]         n_weight;
    logic [7:0]         n_inp;
    logic [7:0]         n_ans;
    logic               n_ready;
    logic               out_valid;
    logic               out_ready;
    logic [7:0]         out_data;
    logic               out_err;
    logic               busy;

    int checks   = 0;
    int failures = 0;
    logic [8:0] exp_q [$];

    neuron_operand_loader #(.N(N), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_weight (in_weight),
        .in_data   (in_data),
        .n_start   (n_start),
        .n_readloc (n_readloc),
        .n_weight  (n_weight),
        .n_inp     (n_inp),
        .n_ans     (n_ans),
        .n_ready   (n_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents four pairs back-to-back; returns at the start of the FIRE cycle
    task automatic load4(input logic [7:0] base);
        for (int i = 0; i < 4; i++) begin
            in_valid  = 1'b1;
            in_weight = base + 8'(2 * i);
            in_data   = base + 8'(2 * i + 1);
            #1;
            check("load_in_ready", in_ready, 1'b1);
            check("load_no_start", n_start, 1'b0);
            tick();
        end
        in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result: got %0h expected none", {out_err, out_data});
            end else begin
                check("result", {out_err, out_data}, exp_q.pop_front());
            end
        end
    end

    initial begin
        rst = 1'b0; clr = 1'b0; in_valid = 1'b0; in_weight = '0; in_data = '0;
        n_readloc = '0; n_ans = '0; n_ready = 1'b0; out_ready = 1'b0;
        #12;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_n_start", n_start, 1'b0);
        check("rst_out_data", out_data, 8'h00);
        check("rst_out_err", out_err, 1'b0);
        rst = 1'b1;
        tick();

        // Evaluation 1: load, fire, operand mux sweep, capture
        load4(8'h01);
        #1;
        check("fire_n_start", n_start, 1'b1);
        check("fire_in_ready", in_ready, 1'b0);
        check("fire_busy", busy, 1'b1);
        tick();
        check("blank_n_start", n_start, 1'b0);
        tick();
        for (int r = 0; r <= 4; r++) begin
            n_readloc = 3'(r);
            #1;
            check("mux_weight", n_weight, (r < 4) ? 8'(2 * r + 1) : 8'h00);
            check("mux_inp", n_inp, (r < 4) ? 8'(2 * r + 2) : 8'h00);
            tick();
        end
        n_readloc = '0;
        n_ready = 1'b1; n_ans = 8'h3C;
        exp_q.push_back({1'b0, 8'h3C});
        tick();
        n_ready = 1'b0;
        #1;
        check("e1_out_valid", out_valid, 1'b1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        #1;
        check("e1_back_in_ready", in_ready, 1'b1);
        check("e1_back_busy", busy, 1'b0);

        // Evaluation 2: stale ready in blanking cycle, held output
        load4(8'h01);
        tick();
        n_ready = 1'b1; n_ans = 8'h11;
        tick();
        n_ans = 8'h2A;
        exp_q.push_back({1'b0, 8'h2A});
        #1;
        check("blank_ignored", out_valid, 1'b0);
        tick();
        n_ready = 1'b0; n_ans = 8'h00;
        #1;
        check("cap_out_valid", out_valid, 1'b1);
        check("cap_out_data", out_data, 8'h2A);
        for (int h = 0; h < 3; h++) begin
            tick();
            check("hold_out_valid", out_valid, 1'b1);
            check("hold_out_data", out_data, 8'h2A);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        #1;
        check("e2_back_in_ready", in_ready, 1'b1);

        // clr mid-load drops the coincident pair and rewinds the write pointer
        in_valid = 1'b1; in_weight = 8'hA0; in_data = 8'hA1;
        tick();
        in_weight = 8'hA2; in_data = 8'hA3;
        tick();
        in_weight = 8'hEE; in_data = 8'hEF; clr = 1'b1;
        tick();
        clr = 1'b0; in_valid = 1'b0;
        load4(8'h10);
        #1;
        check("clr_fire", n_start, 1'b1);
        tick();
        tick();
        n_readloc = 3'd0;
        #1;
        check("clr_w0", n_weight, 8'h10);
        check("clr_d0", n_inp, 8'h11);
        n_readloc = 3'd2;
        #1;
        check("clr_w2", n_weight, 8'h14);
        check("clr_d2", n_inp, 8'h15);
        n_readloc = '0;
        n_ready = 1'b1; n_ans = 8'h5C;
        exp_q.push_back({1'b0, 8'h5C});
        tick();
        n_ready = 1'b0; out_ready = 1'b1;
        #1;
        check("clr_out_valid", out_valid, 1'b1);
        tick();
        out_ready = 1'b0;

        // Asynchronous reset while busy
        load4(8'h20);
        #1;
        check("ar_pre_start", n_start, 1'b1);
        tick();
        #2;
        rst = 1'b0;
        n_readloc = 3'd1;
        #1;
        check("ar_busy", busy, 1'b0);
        check("ar_n_start", n_start, 1'b0);
        check("ar_out_valid", out_valid, 1'b0);
        check("ar_bank_cleared", n_weight, 8'h00);
        #2;
        rst = 1'b1;
        n_readloc = '0;
        tick();
        check("ar_in_ready", in_ready, 1'b1);
        load4(8'h30);
        #1;
        check("ar_refire", n_start, 1'b1);
        tick();
        tick();
        n_ready = 1'b1; n_ans = 8'h77;
        exp_q.push_back({1'b0, 8'h77});
        tick();
        n_ready = 1'b0; out_ready = 1'b1;
        #1;
        check("ar_out_err", out_err, 1'b0);
        tick();
        out_ready = 1'b0;

`ifdef NEURON_LOADER_TIMEOUT_EN
        // Timeout without any neuron result
        load4(8'h40);
        tick();
        repeat (7) tick();
        check("to_not_yet", out_valid, 1'b0);
        exp_q.push_back({1'b1, 8'hFF});
        tick();
        check("to_out_valid", out_valid, 1'b1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        // Result arriving on the expiry cycle wins
        load4(8'h50);
        tick();
        repeat (7) tick();
        n_ready = 1'b1; n_ans = 8'h05;
        exp_q.push_back({1'b0, 8'h05});
        tick();
        n_ready = 1'b0;
        check("to_race_valid", out_valid, 1'b1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
`endif

        repeat (3) tick();
        check("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/neuron_operand_loader.md
# neuron_operand_loader

Upstream feeder for the single-neuron datapath. It accepts N (weight, input) byte pairs over a valid/ready stream and stores them in local register banks. It then fires a one-cycle start pulse to the neuron and serves operand bytes combinationally, indexed by the neuron's read location. It captures the neuron's 8-bit result when the neuron signals ready and presents it downstream on a valid/ready output.

## Interface
- N, 8: operand pairs per neuron evaluation; must be ≥2.
- TIMEOUT, 64: cycles allowed in RUN before abort; only used when the timeout feature is compiled in.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset; one clock and reset domain for the whole block.
- clr  in  1  synchronous abort; returns the block to LOAD.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  loader can accept a pair.
- in_weight  in  8  weight byte.
- in_data  in  8  input byte.
- n_start  out  1  one-cycle start pulse to the neuron.
- n_readloc  in  $clog2(N)+1  neuron read index.
- n_weight  out  8  weight operand to the neuron.
- n_inp  out  8  input operand to the neuron.
- n_ans  in  8  neuron result.
- n_ready  in  1  neuron result valid.
- out_valid  out  1  result held for downstream.
- out_ready  in  1  downstream accepts the result.
- out_data  out  8  captured result.
- out_err  out  1  result produced by timeout; constant 0 without the macro.
- busy  out  1  high in FIRE, RUN and OUT.

## Operation
- States:
  - LOAD: in_ready=1. Each in_valid&in_ready writes wbank[wr_ptr]=in_weight and dbank[wr_ptr]=in_data, then wr_ptr++. A handshake at wr_ptr==N-1 moves to FIRE and sets wr_ptr=0.
  - FIRE: n_start=1 for exactly this cycle. Always moves to RUN.
  - RUN: the first RUN cycle is blanking and ignores n_ready, so a stale ready from the previous evaluation is not captured. From the second cycle on, n_ready=1 captures out_data=n_ans and out_err=0, then moves to OUT.
  - OUT: out_valid=1. out_data and out_err are held stable. On out_ready, moves to LOAD.
- Operand mux is combinational, zero latency:
  - n_weight = wbank[n_readloc] and n_inp = dbank[n_readloc] when n_readloc < N.
  - Otherwise both are 8'h00.
- Operand banks change only in LOAD, so operands are stable throughout RUN.
- in_ready=0 outside LOAD. in_valid is ignored outside LOAD.
- clr has highest priority in every state:
  - next state LOAD, wr_ptr=0, out_valid=0, n_start=0, timeout counter=0.
  - Bank contents are retained. A handshake in the same cycle as clr is dropped.
- out_valid&out_ready and n_ready in the same cycle cannot conflict, since they belong to different states.

## Timing
- Reset (rst low, asynchronous):
  - state=LOAD, wr_ptr=0, banks=0, n_start=0, out_valid=0, out_data=0, out_err=0, busy=0.
  - in_ready=1 from the first cycle after release.
- Last load handshake in cycle t:
  - n_start is high in t+1.
  - RUN blanking is t+2.
  - n_ready is sampled from t+3.
- n_ready first seen in cycle k: out_valid is high from k+1.
- Throughput: N load cycles + 2 + neuron latency + ≥1 OUT cycle per evaluation.
- out_ready held high in OUT: LOAD is re-entered the next cycle and in_ready rises then.

## Configuration
- NEURON_LOADER_TIMEOUT_EN defined:
  - A counter runs in RUN, cleared on RUN entry.
  - If TIMEOUT cycles pass without a captured n_ready, the block enters OUT with out_data=8'hFF and out_err=1.
  - n_ready arriving in the same cycle the count expires wins: normal capture, out_err=0.
- Macro not defined:
  - No counter. RUN waits indefinitely.
  - out_err is tied to 0.

## Test plan
- Reset/load, N=4: release rst, send pairs (1,2),(3,4),(5,6),(7,8) back-to-back -> in_ready stays 1 through the 4 handshakes, n_start pulses exactly once 1 cycle after the 4th, in_ready=0 from that cycle.
- Operand mux, N=4: during RUN drive n_readloc 0..4 -> n_weight/n_inp = 1/2, 3/4, 5/6, 7/8, then 0/0 at index 4.
- Blanking and capture: n_ready=1 in the blanking cycle with n_ans=8'h11, then n_ready=1 next cycle with n_ans=8'h2A -> out_data=8'h2A, out_valid=1 one cycle later; hold out_ready=0 for 3 cycles -> out_data stable; then out_ready=1 -> LOAD.
- clr mid-load: after 2 handshakes assert clr together with a third in_valid -> that pair is dropped, wr_ptr=0, a subsequent full load of 4 pairs fires n_start.
- Async reset in RUN: pull rst low mid-cycle -> out_valid, busy and n_start fall without waiting for a clock edge; the block restarts in LOAD.
- Timeout (macro on, TIMEOUT=8): never assert n_ready -> 8 cycles into RUN, out_valid=1, out_data=8'hFF, out_err=1; repeat with n_ready on the expiry cycle and n_ans=8'h05 -> out_data=8'h05, out_err=0.
